// File: rtl/xnor_pop_pkg.sv
// rtl/xnor_pop_pkg.sv - shared widths, FSM state type and width helper for the XNOR-popcount accumulator
package xnor_pop_pkg;

   localparam int DEF_W     = 64;
   localparam int DEF_ACC_W = 16;

   typedef enum logic [1:0] {
      ACCUM = 2'd0,
      DRAIN = 2'd1,
      HOLD  = 2'd2
   } state_t;

   // bits needed to hold the values 0..n
   function automatic int clog2_plus1(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < (n + 1)) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/xnor_popcount_accum_if.sv
// rtl/xnor_popcount_accum_if.sv - chunk input and result output handshakes of the XNOR-popcount accumulator
interface xnor_popcount_accum_if #(
   parameter int W     = xnor_pop_pkg::DEF_W,
   parameter int ACC_W = xnor_pop_pkg::DEF_ACC_W
);
   logic             in_valid;
   logic             in_ready;
   logic [W-1:0]     in_x;
   logic [W-1:0]     in_w;
   logic             in_last;
   logic [ACC_W-1:0] threshold;
   logic             out_valid;
   logic             out_ready;
   logic [ACC_W-1:0] out_sum;
   logic             out_bit;
   logic             out_ovf;

   modport slave (
      input  in_valid, in_x, in_w, in_last, threshold, out_ready,
      output in_ready, out_valid, out_sum, out_bit, out_ovf
   );

   modport master (
      output in_valid, in_x, in_w, in_last, threshold, out_ready,
      input  in_ready, out_valid, out_sum, out_bit, out_ovf
   );
endinterface

// File: rtl/xnor_popcount_chunk.sv
// rtl/xnor_popcount_chunk.sv - combinational W-bit XNOR-popcount built as a recursive balanced adder tree
module xnor_popcount_chunk
   import xnor_pop_pkg::*;
#(
   parameter int  W    = 64,
   localparam int PC_W = clog2_plus1(W)
) (
   input  logic [W-1:0]    i_x,
   input  logic [W-1:0]    i_w,
   output logic [PC_W-1:0] o_count
);

   if (W == 1) begin : g_leaf
      assign o_count = PC_W'(i_x ~^ i_w);
   end else begin : g_split
      localparam int WL = W / 2;
      localparam int WH = W - WL;
      localparam int PL = clog2_plus1(WL);
      localparam int PH = clog2_plus1(WH);

      logic [PL-1:0] w_lo;
      logic [PH-1:0] w_hi;

      xnor_popcount_chunk #(.W(WL)) u_lo (
         .i_x     (i_x[WL-1:0]),
         .i_w     (i_w[WL-1:0]),
         .o_count (w_lo)
      );

      xnor_popcount_chunk #(.W(WH)) u_hi (
         .i_x     (i_x[W-1:WL]),
         .i_w     (i_w[W-1:WL]),
         .o_count (w_hi)
      );

      assign o_count = PC_W'(w_lo) + PC_W'(w_hi);
   end

endmodule

// File: rtl/xnor_popcount_accum.sv
// rtl/xnor_popcount_accum.sv - streaming XNOR-popcount accumulator with threshold compare; XNOR_POPCOUNT_SAT_EN selects saturating add
module xnor_popcount_accum
   import xnor_pop_pkg::*;
#(
   parameter int W     = DEF_W,
   parameter int ACC_W = DEF_ACC_W
) (
   input logic                  clk,
   input logic                  rst,
   xnor_popcount_accum_if.slave bus
);

   localparam int PC_W = clog2_plus1(W);

   state_t           r_state;
   state_t           w_state_nxt;
   logic             w_in_ready;
   logic             w_accept;
   logic [PC_W-1:0]  w_pc;
   logic [PC_W-1:0]  r_pc;
   logic             r_s1_valid;
   logic             r_s1_last;
   logic [ACC_W-1:0] r_acc;
   logic [ACC_W-1:0] r_thr;
   logic [ACC_W-1:0] w_sum;
   logic [ACC_W-1:0] r_out_sum;
   logic             r_out_bit;
   logic             r_out_valid;

   xnor_popcount_chunk #(.W(W)) u_chunk (
      .i_x     (bus.in_x),
      .i_w     (bus.in_w),
      .o_count (w_pc)
   );

   assign w_accept      = bus.in_valid && w_in_ready;
   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.out_sum   = r_out_sum;
   assign bus.out_bit   = r_out_bit;

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) r_state <= ACCUM;
      else     r_state <= w_state_nxt;
   end

   // next state and input-side ready; ready is held low while rst is asserted
   always_comb begin
      w_state_nxt = r_state;
      w_in_ready  = 1'b0;
      case (r_state)
         ACCUM: begin
            w_in_ready = !rst;
            if (bus.in_valid && !rst && bus.in_last) w_state_nxt = DRAIN;
         end
         DRAIN: w_state_nxt = HOLD;
         HOLD: begin
            if (r_out_valid && bus.out_ready) w_state_nxt = ACCUM;
         end
         default: w_state_nxt = ACCUM;
      endcase
   end

   // threshold is captured together with the last beat of a vector
   always_ff @(posedge clk) begin
      if (rst)                           r_thr <= '0;
      else if (w_accept && bus.in_last)  r_thr <= bus.threshold;
   end

   // stage 1: register the per-chunk popcount and its framing
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
         r_s1_last  <= 1'b0;
         r_pc       <= '0;
      end else begin
         r_s1_valid <= w_accept;
         r_s1_last  <= w_accept && bus.in_last;
         if (w_accept) r_pc <= w_pc;
      end
   end

`ifdef XNOR_POPCOUNT_SAT_EN
   logic [ACC_W:0] w_sum_wide;
   logic           w_sat;
   logic           r_ovf_acc;
   logic           r_out_ovf;

   assign w_sum_wide  = {1'b0, r_acc} + (ACC_W+1)'(r_pc);
   assign w_sat       = w_sum_wide[ACC_W];
   assign w_sum       = w_sat ? {ACC_W{1'b1}} : w_sum_wide[ACC_W-1:0];
   assign bus.out_ovf = r_out_ovf;

   // sticky saturation flag per vector; the reported flag drops when the next vector begins
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ovf_acc <= 1'b0;
         r_out_ovf <= 1'b0;
      end else begin
         if (w_accept) r_out_ovf <= 1'b0;
         if (r_s1_valid) begin
            if (r_s1_last) begin
               r_ovf_acc <= 1'b0;
               r_out_ovf <= r_ovf_acc | w_sat;
            end else begin
               r_ovf_acc <= r_ovf_acc | w_sat;
            end
         end
      end
   end
`else
   assign w_sum       = r_acc + ACC_W'(r_pc);
   assign bus.out_ovf = 1'b0;
`endif

   // stage 2: accumulate, and on the last chunk publish the result and restart the sum
   always_ff @(posedge clk) begin
      if (rst) begin
         r_acc       <= '0;
         r_out_sum   <= '0;
         r_out_bit   <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         if (r_out_valid && bus.out_ready) r_out_valid <= 1'b0;
         if (r_s1_valid) begin
            if (r_s1_last) begin
               r_acc       <= '0;
               r_out_sum   <= w_sum;
               r_out_bit   <= (w_sum > r_thr);
               r_out_valid <= 1'b1;
            end else begin
               r_acc <= w_sum;
            end
         end
      end
   end

endmodule

// File: tb/tb_xnor_popcount_accum.sv
// tb/tb_xnor_popcount_accum.sv - randomized scoreboard bench for xnor_popcount_accum
module tb_xnor_popcount_accum;

   localparam int W     = 64;
   localparam int ACC_W = 8;
   localparam int MAXV  = (1 << ACC_W) - 1;

   typedef struct {
      logic [ACC_W-1:0] sum;
      logic             gt;
      logic             ovf;
      int               acc_cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;
   int   rdy_mode = 0;
   int   stall = 0;
   int   hs_cyc = -100;
   bit   seen = 0;
   exp_t q[$];

   logic [W-1:0] bx[16];
   logic [W-1:0] bw[16];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   xnor_popcount_accum_if #(.W(W), .ACC_W(ACC_W)) bus ();

   xnor_popcount_accum #(.W(W), .ACC_W(ACC_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      errors++;
      $display("FAIL %s: timed out at cycle %0d", name, cyc);
   endtask

   // result consumer behaviour
   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         0: bus.out_ready = 1'b1;
         1: begin
            if (bus.out_valid && stall < 5) begin
               bus.out_ready = 1'b0;
               stall++;
            end else if (bus.out_valid) begin
               bus.out_ready = 1'b1;
            end else begin
               bus.out_ready = 1'b0;
               stall = 0;
            end
         end
         default: bus.out_ready = 1'($urandom_range(1));
      endcase
   end

   // monitor: every cycle a result is shown it must match the oldest expected entry
   always @(negedge clk) begin
      if (rst) begin
         seen = 0;
      end else if (bus.out_valid) begin
         if (q.size() == 0) begin
            timeout("spurious_out_valid");
         end else begin
            if (!seen) begin
               chk("latency", 64'(cyc - q[0].acc_cyc), 64'd2);
               seen = 1;
            end
            chk("out_sum", 64'(bus.out_sum), 64'(q[0].sum));
            chk("out_bit", 64'(bus.out_bit), 64'(q[0].gt));
            chk("out_ovf", 64'(bus.out_ovf), 64'(q[0].ovf));
            chk("hold_in_ready", 64'(bus.in_ready), 64'd0);
            if (bus.out_ready) begin
               hs_cyc = cyc;
               void'(q.pop_front());
               seen = 0;
            end
         end
      end
   end

   task automatic wait_accept(output int accc);
      int budget;
      budget = 0;
      accc = cyc;
      forever begin
         @(negedge clk);
         if (bus.in_ready) begin
            accc = cyc;
            @(posedge clk);
            #1;
            break;
         end
         budget++;
         if (budget > 300) begin
            timeout("accept");
            break;
         end
         @(posedge clk);
         #1;
      end
   endtask

   // drives bx/bw[0..n-1] as one vector and records the expected result from plain arithmetic
   task automatic send_vector(input int n, input logic [ACC_W-1:0] thr, input int gap_pct,
                              output int first_a, output int last_a);
      int total;
      int m;
      int a;
      bit ovf;
      total = 0;
      ovf = 0;
      first_a = 0;
      last_a = 0;
      for (int b = 0; b < n; b++) begin
         while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
            bus.in_valid = 1'b0;
            bus.in_x = {$urandom, $urandom};
            bus.in_last = 1'($urandom_range(1));
            @(posedge clk);
            #1;
         end
         bus.in_valid  = 1'b1;
         bus.in_x      = bx[b];
         bus.in_w      = bw[b];
         bus.in_last   = (b == n - 1);
         bus.threshold = (b == n - 1) ? thr : ACC_W'($urandom);
         wait_accept(a);
         if (b == 0) first_a = a;
         last_a = a;
         m = $countones(~(bx[b] ^ bw[b]));
`ifdef XNOR_POPCOUNT_SAT_EN
         total = total + m;
         if (total > MAXV) begin
            total = MAXV;
            ovf = 1;
         end
`else
         total = (total + m) % (MAXV + 1);
`endif
      end
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      q.push_back('{sum: ACC_W'(total), gt: (total > int'(thr)), ovf: ovf, acc_cyc: last_a});
      @(negedge clk);
      chk("drain_in_ready", 64'(bus.in_ready), 64'd0);
   endtask

   task automatic wait_idle();
      int budget;
      budget = 0;
      while (q.size() != 0 || bus.out_valid) begin
         @(posedge clk);
         #1;
         budget++;
         if (budget > 500) begin
            timeout("idle");
            break;
         end
      end
   endtask

   task automatic set_4beat();
      bx[0] = '1; bw[0] = '1;
      bx[1] = '0; bw[1] = '1;
      bx[2] = '0; bw[2] = {32'hFFFF_FFFF, 32'h0};
      bx[3] = '0; bw[3] = ~64'h3FF;
   endtask

   initial begin
      int fa, la, prev_la, a;
      bus.in_valid  = 1'b0;
      bus.in_x      = '0;
      bus.in_w      = '0;
      bus.in_last   = 1'b0;
      bus.threshold = '0;

      // reset values
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_out_sum", 64'(bus.out_sum), 64'd0);
      chk("rst_out_bit", 64'(bus.out_bit), 64'd0);
      chk("rst_out_ovf", 64'(bus.out_ovf), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
      @(posedge clk);
      #1;

      // single-beat all-match vector
      rdy_mode = 0;
      bx[0] = '1; bw[0] = '1;
      send_vector(1, 8'd63, 0, fa, la);
      wait_idle();

      // 64/0/32/10 back-to-back, both sides of the threshold
      set_4beat();
      send_vector(4, 8'd106, 0, fa, la);
      send_vector(4, 8'd105, 0, fa, la);
      wait_idle();

      // gaps and a stalled consumer; the next vector must wait for the handshake
      rdy_mode = 1;
      send_vector(4, 8'd106, 40, fa, la);
      bx[0] = {$urandom, $urandom}; bw[0] = {$urandom, $urandom};
      send_vector(1, 8'd20, 0, fa, la);
      chk("start_after_hs", 64'(fa - hs_cyc), 64'd1);
      wait_idle();
      set_4beat();

      // reset on the third beat: nothing may come out, and the sum must restart
      rdy_mode = 0;
      for (int b = 0; b < 2; b++) begin
         bus.in_valid = 1'b1; bus.in_x = bx[b]; bus.in_w = bw[b]; bus.in_last = 1'b0;
         wait_accept(a);
      end
      bus.in_valid = 1'b1; bus.in_x = bx[2]; bus.in_w = bw[2]; bus.in_last = 1'b1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("midrst_in_ready", 64'(bus.in_ready), 64'd0);
      chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("midrst_out_sum", 64'(bus.out_sum), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_last = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      bx[0] = '0; bw[0] = ~64'h1FFFF;
      send_vector(1, 8'd16, 0, fa, la);
      wait_idle();

      // 5 x 64 matches overflows an 8-bit accumulator
      for (int b = 0; b < 5; b++) begin bx[b] = '1; bw[b] = '1; end
      send_vector(5, 8'd0, 0, fa, la);
      wait_idle();

      // consumer always ready: 1-cycle pulses, one vector every 3 cycles
      prev_la = 0;
      for (int v = 0; v < 3; v++) begin
         bx[0] = {$urandom, $urandom}; bw[0] = {$urandom, $urandom};
         send_vector(1, ACC_W'($urandom), 0, fa, la);
         if (v > 0) chk("vector_spacing", 64'(la - prev_la), 64'd3);
         prev_la = la;
      end
      wait_idle();

      // randomized vectors with random gaps and random back-pressure
      rdy_mode = 2;
      for (int v = 0; v < 25; v++) begin
         int n;
         n = $urandom_range(1, 5);
         for (int b = 0; b < n; b++) begin
            bx[b] = {$urandom, $urandom};
            bw[b] = {$urandom, $urandom};
         end
         send_vector(n, ACC_W'($urandom), 30, fa, la);
      end
      wait_idle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
